// File: rtl/nano_loader_pkg.sv
// Shared types and constants for the nano_riscv program loader.
// Holds the frame state encoding, the default start byte and the header length.
package nano_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         HDR_BYTES     = 3;

endpackage

// File: rtl/nano_loader_pack.sv
// Byte-to-word packer with running XOR checksum for the program loader.
// The word output already includes din, so it is the full word on the 4th shift.
module nano_loader_pack (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [7:0]  csum
);

  logic [31:0] shreg;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum_q;

  // Little-endian packing: the newest byte enters at the top, so the first byte ends in bits 7:0.
  assign word       = {din, shreg[31:8]};
  assign word_ready = shift && (byte_cnt == 2'd3);
  assign csum       = csum_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
      csum_q   <= '0;
    end else if (shift) begin
      shreg    <= word;
      byte_cnt <= byte_cnt + 2'd1;
      csum_q   <= csum_q ^ din;
    end
  end

endmodule

// File: rtl/nano_loader.sv
// Framed-stream program loader: writes 32-bit words from address 0 and holds
// the core in reset until a frame with a matching XOR checksum has been loaded.
module nano_loader
  import nano_loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;

  state_t             state, next_state;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   len;
  logic [7:0]         len_lo;
  logic [15:0]        frame_len;
  logic               accept;

  logic               pack_clear, pack_shift, pack_word_ready;
  logic [31:0]        pack_word;
  logic [7:0]         pack_csum;

  logic               cnt_clr, cnt_inc, len_lo_ld, len_ld;
  logic               nxt_we, nxt_ready, nxt_busy, nxt_done, nxt_err, nxt_core_rst;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [31:0]        nxt_wdata;

  assign accept    = i_byte_valid && o_byte_ready;
  assign frame_len = {i_byte, len_lo};

  nano_loader_pack u_pack (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .clear      (pack_clear),
    .shift      (pack_shift),
    .din        (i_byte),
    .word       (pack_word),
    .word_ready (pack_word_ready),
    .csum       (pack_csum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      len          <= '0;
      len_lo       <= '0;
      o_byte_ready <= 1'b1;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_core_rst   <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state <= next_state;
      if (cnt_clr)      word_cnt <= '0;
      else if (cnt_inc) word_cnt <= word_cnt + CNT_W'(1);
      if (len_lo_ld)    len_lo   <= i_byte;
      if (len_ld)       len      <= frame_len[CNT_W-1:0];
      o_byte_ready <= nxt_ready;
      o_mem_we     <= nxt_we;
      o_mem_addr   <= nxt_addr;
      o_mem_wdata  <= nxt_wdata;
      o_core_rst   <= nxt_core_rst;
      o_busy       <= nxt_busy;
      o_done       <= nxt_done;
      o_err        <= nxt_err;
    end
  end

  // Outputs are computed from the next state so that every port comes straight from a flop.
  always_comb begin
    next_state   = state;
    pack_clear   = 1'b0;
    pack_shift   = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    len_lo_ld    = 1'b0;
    len_ld       = 1'b0;
    nxt_we       = 1'b0;
    nxt_addr     = o_mem_addr;
    nxt_wdata    = o_mem_wdata;
    nxt_core_rst = o_core_rst;
    nxt_done     = o_done;
    nxt_err      = o_err;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && i_byte == MAGIC) begin
          next_state   = S_LEN_LO;
          pack_clear   = 1'b1;
          cnt_clr      = 1'b1;
          nxt_core_rst = 1'b1;
          nxt_done     = 1'b0;
          nxt_err      = 1'b0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_ld  = 1'b1;
          next_state = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          // N == 2**ADDR_W is the largest legal frame; the extra counter bit allows it.
          if (frame_len == 16'd0 || {1'b0, frame_len} > MAX_WORDS) begin
            next_state = S_ERR;
            nxt_err    = 1'b1;
          end else begin
            len_ld     = 1'b1;
            next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          pack_shift = 1'b1;
          if (pack_word_ready) begin
            next_state = S_WRITE;
            nxt_we     = 1'b1;
            nxt_addr   = word_cnt[ADDR_W-1:0];
            nxt_wdata  = pack_word;
          end
        end
      end
      S_WRITE: begin
        cnt_inc    = 1'b1;
        next_state = ((word_cnt + CNT_W'(1)) == len) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          if (i_byte == pack_csum) begin
            next_state   = S_DONE;
            nxt_done     = 1'b1;
            nxt_core_rst = 1'b0;
          end else begin
            next_state = S_ERR;
            nxt_err    = 1'b1;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase

    nxt_ready = (next_state != S_WRITE);
    nxt_busy  = (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                (next_state == S_DATA)   || (next_state == S_WRITE)  ||
                (next_state == S_CSUM);
  end

endmodule

// File: tb/tb_nano_loader.sv
// Table-driven self-checking bench for nano_loader, plus hand sequences for
// mid-frame reset and the largest legal frame (N = 1024 words).
module tb_nano_loader;

  localparam int ADDR_W = 10;

  // Expected flag sets {ready, busy, done, err, core_rst} after an edge
  localparam logic [4:0] F_IDLE = 5'b10001;
  localparam logic [4:0] F_BUSY = 5'b11001;
  localparam logic [4:0] F_WR   = 5'b01001;
  localparam logic [4:0] F_DONE = 5'b10100;
  localparam logic [4:0] F_ERR  = 5'b10011;

  typedef struct {
    logic              rst;
    logic [7:0]        b;
    logic              v;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [4:0]        flags;
  } vec_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [7:0]        i_byte = 8'h00;
  logic              i_byte_valid = 1'b0;
  logic              o_byte_ready, o_mem_we, o_core_rst, o_busy, o_done, o_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  always #5 i_clk = ~i_clk;

  nano_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_core_rst   (o_core_rst),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  function automatic vec_t row(logic rst, logic [7:0] b, logic v, logic we,
                               logic [ADDR_W-1:0] addr, logic [31:0] wdata, logic [4:0] flags);
    vec_t r;
    r.rst = rst; r.b = b; r.v = v; r.we = we; r.addr = addr; r.wdata = wdata; r.flags = flags;
    return r;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [7:0] b, input logic v);
    i_rst = rst;
    i_byte = b;
    i_byte_valid = v;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata, input logic [4:0] flags, input logic chk_data);
    logic [5:0] act, exp;
    act = {o_mem_we, o_byte_ready, o_busy, o_done, o_err, o_core_rst};
    exp = {we, flags};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s flags{we,rdy,busy,done,err,crst}: got %b expected %b", name, act, exp);
    end
    if (chk_data) begin
      n_checks++;
      if (o_mem_addr !== addr || o_mem_wdata !== wdata) begin
        n_errors++;
        $display("[TB] FAIL %s write: got addr=%0d data=%h expected addr=%0d data=%h",
                 name, o_mem_addr, o_mem_wdata, addr, wdata);
      end
    end
  endtask

  // The two-word reference frame up to and including its second write
  task automatic pushFrameBody();
    vecs.push_back(row(0, 8'hA5, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h02, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h13, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 1, 0, 32'h00000013, F_WR));
    vecs.push_back(row(0, 8'h00, 0, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h93, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h10, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 1, 1, 32'h00100093, F_WR));
    vecs.push_back(row(0, 8'h00, 0, 0, 0, 0, F_BUSY));
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  csum;

    // Reset, then valid frame
    vecs.push_back(row(1, 8'h00, 0, 0, 0, 0, F_IDLE));
    pushFrameBody();
    vecs.push_back(row(0, 8'h90, 1, 0, 0, 0, F_DONE));
    // Reload after success, bad checksum
    pushFrameBody();
    vecs.push_back(row(0, 8'h91, 1, 0, 0, 0, F_ERR));
    // N == 0
    vecs.push_back(row(0, 8'hA5, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_ERR));
    // N == 1025
    vecs.push_back(row(0, 8'hA5, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h01, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h04, 1, 0, 0, 0, F_ERR));
    // Garbage in IDLE, valid gaps mid-word, bytes offered during WRITE
    vecs.push_back(row(1, 8'h00, 0, 0, 0, 0, F_IDLE));
    vecs.push_back(row(0, 8'h55, 1, 0, 0, 0, F_IDLE));
    vecs.push_back(row(0, 8'hFF, 1, 0, 0, 0, F_IDLE));
    vecs.push_back(row(0, 8'hA5, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h02, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h13, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'hEE, 0, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'hEE, 0, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'hEE, 0, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 1, 0, 32'h00000013, F_WR));
    vecs.push_back(row(0, 8'h93, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h93, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h10, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h00, 1, 1, 1, 32'h00100093, F_WR));
    vecs.push_back(row(0, 8'h90, 1, 0, 0, 0, F_BUSY));
    vecs.push_back(row(0, 8'h90, 1, 0, 0, 0, F_DONE));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].b, vecs[i].v);
      checkOutput($sformatf("row%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].flags, vecs[i].we | vecs[i].rst);
    end

    // Reset after 5 data bytes: word1 must never be written
    applyStimulus(0, 8'hA5, 1); checkOutput("mr_magic", 0, 0, 0, F_BUSY, 0);
    applyStimulus(0, 8'h02, 1); checkOutput("mr_lenlo", 0, 0, 0, F_BUSY, 0);
    applyStimulus(0, 8'h00, 1); checkOutput("mr_lenhi", 0, 0, 0, F_BUSY, 0);
    applyStimulus(0, 8'h13, 1);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1); checkOutput("mr_wr0", 1, 0, 32'h00000013, F_WR, 1);
    applyStimulus(0, 8'h93, 1); checkOutput("mr_stall", 0, 0, 0, F_BUSY, 0);
    applyStimulus(0, 8'h93, 1); checkOutput("mr_byte5", 0, 0, 0, F_BUSY, 0);
    applyStimulus(1, 8'h00, 1); checkOutput("mr_reset", 0, 0, 0, F_IDLE, 1);
    applyStimulus(0, 8'h00, 1); checkOutput("mr_drop0", 0, 0, 0, F_IDLE, 0);
    applyStimulus(0, 8'h10, 1); checkOutput("mr_drop1", 0, 0, 0, F_IDLE, 0);
    applyStimulus(0, 8'h00, 1); checkOutput("mr_drop2", 0, 0, 0, F_IDLE, 0);

    // Largest legal frame: N = 1024, last write lands on address 1023
    applyStimulus(0, 8'hA5, 1); checkOutput("big_magic", 0, 0, 0, F_BUSY, 0);
    applyStimulus(0, 8'h00, 1); checkOutput("big_lenlo", 0, 0, 0, F_BUSY, 0);
    applyStimulus(0, 8'h04, 1); checkOutput("big_lenhi", 0, 0, 0, F_BUSY, 0);
    csum = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      w = 32'(i) * 32'h9E3779B1;
      for (int k = 0; k < 3; k++) begin
        applyStimulus(0, w[8*k +: 8], 1);
        csum ^= w[8*k +: 8];
      end
      applyStimulus(0, w[31:24], 1);
      csum ^= w[31:24];
      checkOutput($sformatf("big_wr%0d", i), 1, ADDR_W'(i), w, F_WR, 1);
      applyStimulus(0, 8'h00, 0);
      checkOutput($sformatf("big_gap%0d", i), 0, 0, 0, F_BUSY, 0);
    end
    applyStimulus(0, csum, 1); checkOutput("big_done", 0, 0, 0, F_DONE, 0);
    // A fresh MAGIC after success re-asserts core reset
    applyStimulus(0, 8'hA5, 1); checkOutput("reload", 0, 0, 0, F_BUSY, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
